// File: rtl/riscv_div_pkg.sv
// ---------------------------------------------------------------------------
// riscv_div_pkg
//   Shared types and helpers for the RV32M iterative divider.
//   - div_op_t    : RV32M divide opcode encoding (DIV, DIVU, REM, REMU)
//   - div_state_t : divider FSM states
//   - is_signed() : true for the signed opcodes (DIV, REM)
//   - is_rem()    : true for the remainder opcodes (REM, REMU)
// ---------------------------------------------------------------------------
package riscv_div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

   function automatic logic is_signed(div_op_t op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_rem(div_op_t op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/riscv_div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   Ports:
//     i_rem     [N-1:0]  partial remainder entering the step (< divisor)
//     i_dvd_msb          next dividend bit shifted into the remainder
//     i_divisor [N-1:0]  unsigned divisor magnitude
//     o_rem     [N-1:0]  partial remainder leaving the step
//     o_q_bit            quotient bit produced by the step
// ---------------------------------------------------------------------------
module div_step #(
   parameter int N = 32
) (
   input  logic [N-1:0] i_rem,
   input  logic         i_dvd_msb,
   input  logic [N-1:0] i_divisor,
   output logic [N-1:0] o_rem,
   output logic         o_q_bit
);

   // The shifted remainder can reach 2*divisor-1, so it needs N+1 bits, and the
   // trial subtraction one more bit again to expose a clean borrow.
   logic [N:0]   w_shift;
   logic [N+1:0] w_diff;

   assign w_shift = {i_rem, i_dvd_msb};
   assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
   assign o_q_bit = ~w_diff[N+1];
   // Either branch is below the divisor, so the top bit is always zero here.
   assign o_rem   = o_q_bit ? w_diff[N-1:0] : w_shift[N-1:0];

endmodule

// File: rtl/riscv_div_unit.sv
// ---------------------------------------------------------------------------
// riscv_div_unit
//   Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one operation
//   in flight, valid/ready request and response channels.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req_valid/req_ready request handshake (A, B, op sampled at accept)
//     A, B      [N-1:0]   dividend, divisor
//     op        [1:0]     div_op_t encoding
//     rsp_valid/rsp_ready response handshake
//     Result    [N-1:0]   quotient or remainder, held while rsp_valid & !rsp_ready
//     busy                high while an operation is in CALC or DONE
//   Configuration macro:
//     DIV_EARLY_OUT_EN    divide-by-zero and signed overflow skip the N
//                         iteration cycles and complete one cycle after accept.
//                         Results are identical in both builds.
// ---------------------------------------------------------------------------
module riscv_div_unit
   import riscv_div_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [1:0]   op,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] Result,
   output logic         busy
);

   localparam int CW = $clog2(N);
   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

   div_state_t     r_state;
   logic [CW-1:0]  r_count;
   logic [N-1:0]   r_rem;
   logic [N-1:0]   r_dvd;    // dividend bits shift out the top, quotient bits in the bottom
   logic [N-1:0]   r_dsr;
   logic [N-1:0]   r_a;      // original dividend, needed for the divide-by-zero remainder
   div_op_t        r_op;
   logic           r_neg_q;
   logic           r_neg_r;
   logic           r_div0;
   logic           r_ovf;
   logic           r_fix;    // iterations finished (or skipped); next edge applies fixup
   logic [N-1:0]   r_result;
   logic           r_rsp_valid;
   logic           r_req_ready;
   logic           r_busy;

   div_op_t        w_op;
   logic           w_accept;
   logic           w_sgn;
   logic           w_div0;
   logic           w_ovf;
   logic           w_early;
   logic [N-1:0]   w_abs_a;
   logic [N-1:0]   w_abs_b;
   logic [N-1:0]   w_rem_nx;
   logic           w_q_bit;

   assign w_op     = div_op_t'(op);
   assign w_accept = req_valid & r_req_ready;
   assign w_sgn    = is_signed(w_op);
   assign w_div0   = (B == '0);
   assign w_ovf    = w_sgn && (A == MIN_NEG) && (B == '1);
   assign w_abs_a  = (w_sgn && A[N-1]) ? (~A + 1'b1) : A;
   assign w_abs_b  = (w_sgn && B[N-1]) ? (~B + 1'b1) : B;

`ifdef DIV_EARLY_OUT_EN
   assign w_early = w_div0 | w_ovf;
`else
   assign w_early = 1'b0;
`endif

   div_step #(.N(N)) u_step (
      .i_rem     (r_rem),
      .i_dvd_msb (r_dvd[N-1]),
      .i_divisor (r_dsr),
      .o_rem     (w_rem_nx),
      .o_q_bit   (w_q_bit)
   );

   // Sign correction plus the two RISC-V special cases. Special cases override
   // whatever the iterations produced, so both builds give the same answer.
   function automatic logic [N-1:0] fixup(
      input div_op_t      f_op,
      input logic [N-1:0] f_q,
      input logic [N-1:0] f_r,
      input logic [N-1:0] f_a,
      input logic         f_neg_q,
      input logic         f_neg_r,
      input logic         f_div0,
      input logic         f_ovf
   );
      logic [N-1:0] qf;
      logic [N-1:0] rf;
      if (f_div0) begin
         qf = '1;
         rf = f_a;
      end else if (f_ovf) begin
         qf = f_a;
         rf = '0;
      end else begin
         qf = f_neg_q ? (~f_q + 1'b1) : f_q;
         rf = f_neg_r ? (~f_r + 1'b1) : f_r;
      end
      return is_rem(f_op) ? rf : qf;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_rem       <= '0;
         r_dvd       <= '0;
         r_dsr       <= '0;
         r_a         <= '0;
         r_op        <= DIV;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_div0      <= 1'b0;
         r_ovf       <= 1'b0;
         r_fix       <= 1'b0;
         r_result    <= '0;
         r_rsp_valid <= 1'b0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state     <= CALC;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_count     <= '0;
                  r_rem       <= '0;
                  r_dvd       <= w_abs_a;
                  r_dsr       <= w_abs_b;
                  r_a         <= A;
                  r_op        <= w_op;
                  r_neg_q     <= w_sgn & (A[N-1] ^ B[N-1]);
                  r_neg_r     <= w_sgn & A[N-1];
                  r_div0      <= w_div0;
                  r_ovf       <= w_ovf;
                  r_fix       <= w_early;
               end
            end
            CALC: begin
               if (r_fix) begin
                  // Registered fixup cycle: the final answer lands with DONE.
                  r_result    <= fixup(r_op, r_dvd, r_rem, r_a,
                                       r_neg_q, r_neg_r, r_div0, r_ovf);
                  r_state     <= DONE;
                  r_rsp_valid <= 1'b1;
                  r_fix       <= 1'b0;
               end else begin
                  r_rem <= w_rem_nx;
                  r_dvd <= {r_dvd[N-2:0], w_q_bit};
                  if (r_count == CW'(N-1)) begin
                     r_fix <= 1'b1;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_fix       <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign Result    = r_result;
   assign busy      = r_busy;

endmodule

// File: tb/tb_riscv_div_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_div_unit
//   Directed self-checking bench for riscv_div_unit (N = 32), plus a short
//   randomised run against a $signed/$unsigned reference model.
// ---------------------------------------------------------------------------
module tb_riscv_div_unit;

   localparam int N = 32;
   localparam int TMO = 200;

`ifdef DIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = N + 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [N-1:0]  A;
   logic [N-1:0]  B;
   logic [1:0]    op;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [N-1:0]  Result;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   riscv_div_unit #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .Result    (Result),
      .busy      (busy)
   );

   function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         2'b00:   return ovf ? a : 32'($signed(a) / $signed(b));
         2'b01:   return a / b;
         2'b10:   return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   // Issue one operation and wait for its response. Inputs are scrambled right
   // after acceptance. quiet reports whether req_ready stayed low and busy high
   // for every sampled cycle before the response.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit throttle, output logic [31:0] res, output int lat,
                         output bit ok, output bit quiet);
      int guard;
      ok = 1'b1;
      quiet = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < TMO) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1;
      A = a;
      B = b;
      op = o;
      rsp_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      op = 2'($urandom);
      lat = 0;
      while (!rsp_valid && lat < TMO) begin
         if (req_ready || !busy) quiet = 1'b0;
         @(negedge clk);
         lat++;
         if (throttle) rsp_ready = 1'($urandom_range(0, 1));
      end
      if (!rsp_valid) begin
         ok = 1'b0;
         res = 'x;
      end else begin
         res = Result;
         guard = 0;
         while (!rsp_ready && guard < TMO) begin
            @(negedge clk);
            rsp_ready = 1'($urandom_range(0, 1));
            guard++;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      A = '0;
      B = '0;
      op = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
      end
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      n_checks++;
      if (Result !== 32'd0) begin
         n_fail++; $display("FAIL reset_result: got %h expected 0", Result);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_divu();
      logic [31:0] res;
      int lat;
      bit ok, quiet;
      run_op(2'b01, 32'd100, 32'd7, 1'b0, res, lat, ok, quiet);
      n_checks++;
      if (!ok || res !== 32'd14) begin
         n_fail++; $display("FAIL divu_100_7: got %h expected %h", res, 32'd14);
      end
      n_checks++;
      if (lat !== N + 1) begin
         n_fail++; $display("FAIL divu_latency: got %0d expected %0d", lat, N + 1);
      end
      n_checks++;
      if (!quiet) begin
         n_fail++; $display("FAIL divu_ready_busy: got req_ready/busy violation expected ready=0 busy=1");
      end
      n_checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL divu_back_to_idle: got rr=%b busy=%b rv=%b expected 1 0 0",
                            req_ready, busy, rsp_valid);
      end
   endtask

   task automatic test_signed();
      logic [1:0]  v_op [6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11};
      logic [31:0] v_a  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] v_b  [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'hFFFF_FFFE, 32'hFFFF_FFFE};
      logic [31:0] v_e  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd1,
                                32'd1, 32'd1};
      logic [31:0] res;
      int lat;
      bit ok, quiet;
      for (int i = 0; i < 6; i++) begin
         run_op(v_op[i], v_a[i], v_b[i], 1'b0, res, lat, ok, quiet);
         n_checks++;
         if (!ok || res !== v_e[i]) begin
            n_fail++; $display("FAIL signed_vec%0d: got %h expected %h", i, res, v_e[i]);
         end
      end
   endtask

   task automatic test_special();
      logic [1:0]  v_op [4] = '{2'b00, 2'b11, 2'b00, 2'b10};
      logic [31:0] v_a  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] v_b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] v_e  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      logic [31:0] res;
      int lat;
      bit ok, quiet;
      for (int i = 0; i < 4; i++) begin
         run_op(v_op[i], v_a[i], v_b[i], 1'b0, res, lat, ok, quiet);
         n_checks++;
         if (!ok || res !== v_e[i]) begin
            n_fail++; $display("FAIL special_vec%0d: got %h expected %h", i, res, v_e[i]);
         end
         n_checks++;
         if (lat !== SPECIAL_LAT) begin
            n_fail++; $display("FAIL special_lat%0d: got %0d expected %0d", i, lat, SPECIAL_LAT);
         end
      end
   endtask

   task automatic test_backpressure();
      int guard;
      bit bad;
      @(negedge clk);
      req_valid = 1'b1;
      A = 32'd1000;
      B = 32'd10;
      op = 2'b01;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < TMO) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (!rsp_valid) begin
         n_fail++; $display("FAIL bp_timeout: got rsp_valid=0 expected 1");
      end
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         req_valid = 1'b1;
         A = 32'd77;
         B = 32'd7;
         op = 2'b01;
         @(negedge clk);
         if (rsp_valid !== 1'b1 || Result !== 32'd100 || req_ready !== 1'b0) bad = 1'b1;
      end
      req_valid = 1'b0;
      n_checks++;
      if (bad) begin
         n_fail++; $display("FAIL bp_hold: got unstable rv=%b res=%h rr=%b expected 1 %h 0",
                            rsp_valid, Result, req_ready, 32'd100);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: got rv=%b rr=%b busy=%b expected 0 1 0",
                            rsp_valid, req_ready, busy);
      end
      bad = 1'b0;
      repeat (N + 4) begin
         @(negedge clk);
         if (rsp_valid || busy) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++; $display("FAIL bp_single_transfer: got extra activity expected idle");
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] res;
      int lat;
      bit ok, quiet, pulsed;
      @(negedge clk);
      req_valid = 1'b1;
      A = 32'hDEAD_BEEF;
      B = 32'd3;
      op = 2'b01;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle: got rr=%b busy=%b rv=%b expected 1 0 0",
                            req_ready, busy, rsp_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      pulsed = 1'b0;
      repeat (N + 8) begin
         @(negedge clk);
         if (rsp_valid) pulsed = 1'b1;
      end
      n_checks++;
      if (pulsed) begin
         n_fail++; $display("FAIL abort_no_rsp: got rsp_valid pulse expected none");
      end
      run_op(2'b01, 32'd9, 32'd3, 1'b0, res, lat, ok, quiet);
      n_checks++;
      if (!ok || res !== 32'd3) begin
         n_fail++; $display("FAIL abort_then_divu: got %h expected %h", res, 32'd3);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, exp, res;
      logic [1:0]  o;
      int lat;
      bit ok, quiet;
      for (int i = 0; i < 120; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         exp = ref_model(o, a, b);
         run_op(o, a, b, 1'b1, res, lat, ok, quiet);
         n_checks++;
         if (!ok || res !== exp) begin
            n_fail++; $display("FAIL random%0d op=%0d a=%h b=%h: got %h expected %h",
                               i, o, a, b, res, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_signed();
      test_special();
      test_backpressure();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
